// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller for the 65C02 core.
// Merges up to 8 maskable sources, each in level or edge mode, into the CPU's IRQ input.
// Edge-detects NMI.
// Supplies a per-source low vector byte in page $FF on each vector-fetch acknowledge.
module irq_ctl #(
   parameter int         NCH      = 8,
   parameter logic [7:0] VEC_BASE = 8'hE0
) (
   input  logic           clk,
   input  logic           RST,
   input  logic [NCH-1:0] src,
   input  logic           nmi_in,
   input  logic           RDY,
   input  logic           ack,
   input  logic           ack_nmi,
   input  logic           cfg_we,
   input  logic [1:0]     cfg_addr,
   input  logic [7:0]     cfg_di,
   output logic [7:0]     cfg_do,
   output logic           IRQ,
   output logic           NMI,
   output logic [7:0]     vec_l
);

   logic [NCH-1:0] src_q, src_h;
   logic           nmi_q, nmi_h;
   // High for the first cycle after reset. History is then loaded from the raw pins, so a
   // source already high during reset never looks like a fresh edge.
   logic           settle;
   logic [NCH-1:0] mask, mode, pend;
   logic           nmi_pend, spurious;

   logic [NCH-1:0] act, rise, clr, pend_nxt;
   logic           any;
   logic [2:0]     k;
   logic           eff_ack, irq_ack;
   logic [7:0]     vec_nxt;

   // Zero-extend a channel vector to the 8-bit config bus.
   function automatic logic [7:0] widen(input logic [NCH-1:0] v);
      logic [7:0] w;
      w = '0;
      w[NCH-1:0] = v;
      return w;
   endfunction

   // Fixed-priority pick of the lowest active channel, plus the next pending state.
   always_comb begin
      act = pend & mask;
      any = 1'b0;
      k   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (act[i]) begin
            any = 1'b1;
            k   = 3'(i);
         end
      end
      eff_ack = ack & RDY;
      irq_ack = eff_ack & ~ack_nmi;
      rise    = src_q & ~src_h;
      clr     = '0;
      for (int i = 0; i < NCH; i++) begin
         clr[i] = irq_ack & any & (k == 3'(i));
      end
      if (cfg_we && cfg_addr == 2'd2) begin
         clr = clr | cfg_di[NCH-1:0];
      end
      // A new rise on an edge channel wins over any clear in the same cycle.
      // Level channels simply follow the synchronised input.
      pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & src_q);
      vec_nxt  = VEC_BASE + {4'b0000, k, 1'b0};
   end

   assign IRQ = any;
   assign NMI = nmi_pend;

   // Config read mux; STATUS packs {nmi_pend, spurious, IRQ, 2'b0, k}.
   always_comb begin
      cfg_do = '0;
      case (cfg_addr)
         2'd0:    cfg_do = widen(mask);
         2'd1:    cfg_do = widen(mode);
         2'd2:    cfg_do = widen(pend);
         default: cfg_do = {nmi_pend, spurious, any, 2'b00, k};
      endcase
   end

   // Input synchroniser and edge history.
   always_ff @(posedge clk) begin
      if (RST) begin
         src_q  <= '0;
         src_h  <= '1;
         nmi_q  <= 1'b0;
         nmi_h  <= 1'b1;
         settle <= 1'b1;
      end else begin
         src_q  <= src;
         nmi_q  <= nmi_in;
         src_h  <= settle ? src : src_q;
         nmi_h  <= settle ? nmi_in : nmi_q;
         settle <= 1'b0;
      end
   end

   // Pending state for channels and NMI.
   always_ff @(posedge clk) begin
      if (RST) begin
         pend     <= '0;
         nmi_pend <= 1'b0;
      end else begin
         pend     <= pend_nxt;
         nmi_pend <= (nmi_q & ~nmi_h) | (nmi_pend & ~(eff_ack & ack_nmi));
      end
   end

   // Vector byte and spurious flag, updated only on an effective acknowledge.
   always_ff @(posedge clk) begin
      if (RST) begin
         vec_l    <= 8'hFC;
         spurious <= 1'b0;
      end else if (eff_ack) begin
         if (ack_nmi) begin
            vec_l <= 8'hFA;
         end else if (any) begin
            vec_l    <= vec_nxt;
            spurious <= 1'b0;
         end else begin
            vec_l    <= 8'hFE;
            spurious <= 1'b1;
         end
      end
   end

   // MASK and MODE registers; PEND write-clear is folded into pend_nxt.
   always_ff @(posedge clk) begin
      if (RST) begin
         mask <= '0;
         mode <= '0;
      end else if (cfg_we) begin
         if (cfg_addr == 2'd0) mask <= cfg_di[NCH-1:0];
         if (cfg_addr == 2'd1) mode <= cfg_di[NCH-1:0];
      end
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl.
// A behavioural model tracks sampled input history and applies the pending/ack rules.
// Directed scenarios are followed by a randomized run.
module tb_irq_ctl;

   localparam int         NCH = 8;
   localparam logic [7:0] VB  = 8'hE0;

   logic       clk = 1'b0;
   logic       RST, nmi_in, RDY, ack, ack_nmi, cfg_we;
   logic [7:0] src, cfg_di, cfg_do, vec_l;
   logic [1:0] cfg_addr;
   logic       IRQ, NMI;

   int checks = 0;
   int errors = 0;

   irq_ctl #(.NCH(NCH), .VEC_BASE(VB)) dut (
      .clk(clk), .RST(RST), .src(src), .nmi_in(nmi_in), .RDY(RDY), .ack(ack),
      .ack_nmi(ack_nmi), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_di(cfg_di),
      .cfg_do(cfg_do), .IRQ(IRQ), .NMI(NMI), .vec_l(vec_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [7:0] m_mask, m_mode, m_pend, m_vec;
   bit       m_nmi, m_spur;
   bit [7:0] s1, s2;        // raw src sampled at the previous two edges
   bit       n1, n2;
   int       age;           // non-reset edges seen since the last reset edge
   bit [7:0] act, rise, lvl, clr, np, exp_do;
   bit       nrise, eack, m_irq;
   int       k;

   function automatic int lowest(input bit [7:0] v);
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (RST) begin
         m_mask = 0; m_mode = 0; m_pend = 0; m_nmi = 0; m_spur = 0; m_vec = 8'hFC;
         age = 0;
      end else begin
         act   = m_pend & m_mask;
         k     = lowest(act);
         // A rise needs two samples that were both taken after reset.
         rise  = (age >= 2) ? (s1 & ~s2) : 8'h00;
         nrise = (age >= 2) && n1 && !n2;
         lvl   = (age >= 1) ? s1 : 8'h00;
         eack  = ack && RDY;
         clr   = 0;
         if (eack && !ack_nmi && k >= 0) clr[k] = 1'b1;
         if (cfg_we && cfg_addr == 2'd2) clr = clr | cfg_di;
         for (int n = 0; n < NCH; n++)
            np[n] = m_mode[n] ? (rise[n] || (m_pend[n] && !clr[n])) : lvl[n];
         if (eack) begin
            if (ack_nmi) m_vec = 8'hFA;
            else if (k >= 0) begin m_vec = VB + 8'(2 * k); m_spur = 0; end
            else begin m_vec = 8'hFE; m_spur = 1; end
         end
         m_nmi  = nrise || (m_nmi && !(eack && ack_nmi));
         m_pend = np;
         if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_di;
         if (cfg_we && cfg_addr == 2'd1) m_mode = cfg_di;
         if (age < 10) age++;
      end
      s2 = s1; s1 = src; n2 = n1; n1 = nmi_in;
      #2;
      act   = m_pend & m_mask;
      k     = lowest(act);
      m_irq = (act != 0);
      case (cfg_addr)
         2'd0:    exp_do = m_mask;
         2'd1:    exp_do = m_mode;
         2'd2:    exp_do = m_pend;
         default: exp_do = {m_nmi, m_spur, m_irq, 2'b00, (k >= 0) ? 3'(k) : 3'd0};
      endcase
      chk("irq", {7'd0, IRQ}, {7'd0, m_irq});
      chk("nmi", {7'd0, NMI}, {7'd0, m_nmi});
      chk("vec_l", vec_l, m_vec);
      chk("cfg_do", cfg_do, exp_do);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_di = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic do_ack(input logic nm, input logic rdy);
      ack = 1'b1; ack_nmi = nm; RDY = rdy;
      @(negedge clk);
      ack = 1'b0; ack_nmi = 1'b0; RDY = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input string nm, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      chk(nm, cfg_do, exp);
   endtask

   initial begin
      RST = 1'b1; src = 8'hFF; nmi_in = 1'b1; RDY = 1'b1; ack = 1'b0; ack_nmi = 1'b0;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_di = 8'h00;
      cyc(3);
      // Reset state with all sources high
      chk("rst_irq", {7'd0, IRQ}, 8'd0);
      chk("rst_nmi", {7'd0, NMI}, 8'd0);
      chk("rst_vec", vec_l, 8'hFC);
      rd(2'd2, "rst_pend", 8'h00);
      RST = 1'b0;
      cyc(10);
      chk("hold_irq", {7'd0, IRQ}, 8'd0);
      chk("hold_nmi", {7'd0, NMI}, 8'd0);
      chk("hold_vec", vec_l, 8'hFC);
      src = 8'h00; nmi_in = 1'b0;
      cyc(3);

      // Level channel 0: two-edge latency, ack does not clear
      wr(2'd0, 8'h01); wr(2'd1, 8'h00);
      src = 8'h01;
      cyc(1); chk("lvl_lat1", {7'd0, IRQ}, 8'd0);
      cyc(1); chk("lvl_lat2", {7'd0, IRQ}, 8'd1);
      do_ack(1'b0, 1'b1);
      chk("lvl_vec", vec_l, 8'hE0);
      chk("lvl_irq_held", {7'd0, IRQ}, 8'd1);
      src = 8'h00;
      cyc(1); chk("lvl_drop1", {7'd0, IRQ}, 8'd1);
      cyc(1); chk("lvl_drop2", {7'd0, IRQ}, 8'd0);

      // Edge channels 5 and 2 together: priority order
      wr(2'd0, 8'hFF); wr(2'd1, 8'hFF);
      src = 8'h24; cyc(1); src = 8'h00; cyc(1);
      rd(2'd3, "status_k2", 8'h22);
      do_ack(1'b0, 1'b1);
      chk("edge_vec1", vec_l, 8'hE4);
      rd(2'd2, "edge_pend1", 8'h20);
      do_ack(1'b0, 1'b1);
      chk("edge_vec2", vec_l, 8'hEA);
      rd(2'd2, "edge_pend2", 8'h00);
      chk("edge_irq0", {7'd0, IRQ}, 8'd0);

      // New rise on channel 3 coincides with the ack clearing it
      src = 8'h08; cyc(1); src = 8'h00; cyc(1);
      rd(2'd2, "ch3_pend", 8'h08);
      src = 8'h08; cyc(1);
      src = 8'h00;
      do_ack(1'b0, 1'b1);
      chk("ch3_vec", vec_l, 8'hE6);
      rd(2'd2, "ch3_set_wins", 8'h08);
      do_ack(1'b0, 1'b1);
      rd(2'd2, "ch3_cleared", 8'h00);

      // NMI while IRQ active; RDY gating of ack
      src = 8'h10; cyc(1); src = 8'h00; cyc(1);
      chk("nmi_irq_on", {7'd0, IRQ}, 8'd1);
      nmi_in = 1'b1; cyc(2);
      chk("nmi_set", {7'd0, NMI}, 8'd1);
      do_ack(1'b1, 1'b0);
      chk("nmi_rdy0", {7'd0, NMI}, 8'd1);
      chk("nmi_rdy0_vec", vec_l, 8'hE6);
      do_ack(1'b1, 1'b1);
      chk("nmi_vec", vec_l, 8'hFA);
      chk("nmi_clr", {7'd0, NMI}, 8'd0);
      rd(2'd2, "nmi_pend_keep", 8'h10);
      nmi_in = 1'b0;
      wr(2'd2, 8'h10);
      rd(2'd2, "wr_clear", 8'h00);

      // Spurious ack, then a real one clears the flag
      wr(2'd0, 8'h00);
      do_ack(1'b0, 1'b1);
      chk("spur_vec", vec_l, 8'hFE);
      rd(2'd3, "spur_status", 8'h40);
      wr(2'd0, 8'h02);
      src = 8'h02; cyc(1); src = 8'h00; cyc(1);
      do_ack(1'b0, 1'b1);
      chk("ch1_vec", vec_l, 8'hE2);
      rd(2'd3, "spur_cleared", 8'h00);

      // Reset discards a pending interrupt
      wr(2'd0, 8'hFF);
      src = 8'h40; cyc(1); src = 8'h00; cyc(1);
      chk("pre_rst_irq", {7'd0, IRQ}, 8'd1);
      RST = 1'b1; cyc(1); RST = 1'b0;
      chk("mid_rst_irq", {7'd0, IRQ}, 8'd0);
      chk("mid_rst_vec", vec_l, 8'hFC);
      rd(2'd2, "mid_rst_pend", 8'h00);

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         RST = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
         if ($urandom_range(0, 15) == 0) nmi_in = ~nmi_in;
         RDY      = ($urandom_range(0, 3) != 0);
         ack      = ($urandom_range(0, 3) == 0);
         ack_nmi  = ($urandom_range(0, 3) == 0);
         cfg_we   = ($urandom_range(0, 5) == 0);
         cfg_addr = 2'($urandom);
         cfg_di   = 8'($urandom);
         @(negedge clk);
      end
      RST = 1'b0; ack = 1'b0; cfg_we = 1'b0;
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
